// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcodes, control-word layout, ALUOp codes
// and the immediate formats used by the decode stage.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_HALT = 11'b11111111111;
  // CB and B opcodes are matched on their fixed upper bits only
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam int CTRL_REG2LOC  = 9;
  localparam int CTRL_ALUSRC   = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_UNCOND   = 2;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CB  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [9:0] CTRL_RTYPE = {8'b00010000, ALUOP_R};
  localparam logic [9:0] CTRL_LDUR  = {8'b01111000, ALUOP_MEM};
  localparam logic [9:0] CTRL_STUR  = {8'b11000100, ALUOP_MEM};
  localparam logic [9:0] CTRL_CB    = {8'b10000010, ALUOP_CB};
  localparam logic [9:0] CTRL_B     = {8'b00000001, ALUOP_MEM};

  typedef enum logic [1:0] {
    FMT_NONE,
    FMT_D,
    FMT_CB,
    FMT_B
  } imm_fmt_e;

endpackage

// File: rtl/register_file.sv
// 32x64 LEGv8 register file: two asynchronous read ports, one synchronous
// write port; X31 reads as zero and ignores writes.
module register_file
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [63:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [63:0] o_rdata1,
  output logic [63:0] o_rdata2
);

  logic [63:0] r_regs [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd31)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd31) ? 64'd0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd31) ? 64'd0 : r_regs[i_raddr2];

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 decode stage: latches the fetch bundle, produces the control word,
// register operands, sign-extended immediate and branch redirect for fetch.
module instruction_decode
  import legv8_pkg::*;
(
  input  logic [95:0] outBuf,
  output logic        PCSrc,
  output logic [63:0] BranchAddress,
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteIn,
  input  logic [4:0]  WriteReg,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2,
  output logic [63:0] SignExtImm,
  output logic [9:0]  Ctrl
);

  logic [31:0] r_ir;
  logic [63:0] r_pcr;
  logic [10:0] w_opcode;
  logic [4:0]  w_rd2_addr;
  logic        w_is_cbz;
  logic        w_is_cbnz;
  imm_fmt_e    w_fmt;

  // Decode pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir  <= '0;
      r_pcr <= '0;
    end else begin
      r_ir  <= outBuf[31:0];
      r_pcr <= outBuf[95:32];
    end
  end

  assign w_opcode = r_ir[31:21];

  always_comb begin
    Ctrl      = '0;
    w_fmt     = FMT_NONE;
    w_is_cbz  = 1'b0;
    w_is_cbnz = 1'b0;
    if (w_opcode == OP_ADD || w_opcode == OP_SUB ||
        w_opcode == OP_AND || w_opcode == OP_ORR) begin
      Ctrl = CTRL_RTYPE;
    end else if (w_opcode == OP_LDUR) begin
      Ctrl  = CTRL_LDUR;
      w_fmt = FMT_D;
    end else if (w_opcode == OP_STUR) begin
      Ctrl  = CTRL_STUR;
      w_fmt = FMT_D;
    end else if (w_opcode[10:3] == OP_CBZ) begin
      Ctrl     = CTRL_CB;
      w_fmt    = FMT_CB;
      w_is_cbz = 1'b1;
    end else if (w_opcode[10:3] == OP_CBNZ) begin
      Ctrl      = CTRL_CB;
      w_fmt     = FMT_CB;
      w_is_cbnz = 1'b1;
    end else if (w_opcode[10:5] == OP_B) begin
      Ctrl  = CTRL_B;
      w_fmt = FMT_B;
    end
  end

  always_comb begin
    case (w_fmt)
      FMT_D:   SignExtImm = {{55{r_ir[20]}}, r_ir[20:12]};
      FMT_CB:  SignExtImm = {{45{r_ir[23]}}, r_ir[23:5]};
      FMT_B:   SignExtImm = {{38{r_ir[25]}}, r_ir[25:0]};
      default: SignExtImm = '0;
    endcase
  end

  // CB-type and stores name their second operand in the Rt field
  assign w_rd2_addr = Ctrl[CTRL_REG2LOC] ? r_ir[4:0] : r_ir[20:16];

  register_file u_regs (
    .clk      (clk),
    .rst      (reset),
    .i_we     (RegWriteIn),
    .i_waddr  (WriteReg),
    .i_wdata  (WriteData),
    .i_raddr1 (r_ir[9:5]),
    .i_raddr2 (w_rd2_addr),
    .o_rdata1 (ReadData1),
    .o_rdata2 (ReadData2)
  );

  // PCR holds the next sequential PC, so step back one word to the branch
  assign BranchAddress = (r_pcr - 64'd4) + (SignExtImm << 2);
  assign PCSrc = Ctrl[CTRL_UNCOND] |
                 (w_is_cbz  & (ReadData2 == 64'd0)) |
                 (w_is_cbnz & (ReadData2 != 64'd0));

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-computed vectors for each
// instruction class, register-file corner cases and asynchronous reset.
module tb_instruction_decode;

  logic [95:0] outBuf;
  logic        PCSrc;
  logic [63:0] BranchAddress;
  logic        clk;
  logic        reset;
  logic        RegWriteIn;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [63:0] SignExtImm;
  logic [9:0]  Ctrl;

  int checks;
  int failures;

  instruction_decode dut (
    .outBuf        (outBuf),
    .PCSrc         (PCSrc),
    .BranchAddress (BranchAddress),
    .clk           (clk),
    .reset         (reset),
    .RegWriteIn    (RegWriteIn),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .SignExtImm    (SignExtImm),
    .Ctrl          (Ctrl)
  );

  initial clk = 1'b0;
  always #80 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present a fetch bundle at negedge; sample at posedge + 40
  task automatic load(input logic [63:0] pc, input logic [31:0] ins);
    @(negedge clk);
    outBuf = {pc, ins};
    @(posedge clk);
    #40;
  endtask

  // Writeback one register; sample at posedge + 40
  task automatic wr(input logic [4:0] r, input logic [63:0] d);
    @(negedge clk);
    RegWriteIn = 1'b1;
    WriteReg   = r;
    WriteData  = d;
    @(posedge clk);
    #1;
    RegWriteIn = 1'b0;
    #39;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    outBuf     = '0;
    reset      = 1'b1;
    RegWriteIn = 1'b0;
    WriteReg   = '0;
    WriteData  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ctrl", {54'd0, Ctrl}, 64'd0);
    chk("rst_pcsrc", {63'd0, PCSrc}, 64'd0);
    chk("rst_baddr", BranchAddress, 64'hFFFF_FFFF_FFFF_FFFC);

    // B #3 from 0x4 (next PC 0x8)
    load(64'h8, 32'h1400_0003);
    chk("b_pcsrc", {63'd0, PCSrc}, 64'd1);
    chk("b_baddr", BranchAddress, 64'h10);
    chk("b_ctrl", {54'd0, Ctrl}, {54'd0, 10'b0000000100});
    chk("b_imm", SignExtImm, 64'd3);

    // B #-1 from 0xFC: negative 26-bit offset
    load(64'h100, 32'h17FF_FFFF);
    chk("bneg_imm", SignExtImm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("bneg_baddr", BranchAddress, 64'hF8);

    // CBZ X1, #2 with X1 = 0, then X1 = 5
    load(64'h14, 32'hB400_0041);
    chk("cbz_taken", {63'd0, PCSrc}, 64'd1);
    chk("cbz_baddr", BranchAddress, 64'h18);
    chk("cbz_ctrl", {54'd0, Ctrl}, {54'd0, 10'b1000001001});
    wr(5'd1, 64'd5);
    chk("cbz_nt", {63'd0, PCSrc}, 64'd0);
    load(64'h14, 32'hB500_0041);
    chk("cbnz_taken", {63'd0, PCSrc}, 64'd1);
    wr(5'd1, 64'd0);
    chk("cbnz_nt", {63'd0, PCSrc}, 64'd0);

    // ADD X1, X2, X3
    wr(5'd2, 64'd7);
    wr(5'd3, 64'd9);
    load(64'h20, 32'h8B03_0041);
    chk("add_rd1", ReadData1, 64'd7);
    chk("add_rd2", ReadData2, 64'd9);
    chk("add_ctrl", {54'd0, Ctrl}, {54'd0, 10'b0001000010});
    chk("add_imm", SignExtImm, 64'd0);

    // Same-cycle write and read of X2: old before the edge, new after
    @(negedge clk);
    RegWriteIn = 1'b1;
    WriteReg   = 5'd2;
    WriteData  = 64'h77;
    #1;
    chk("byp_old", ReadData1, 64'd7);
    @(posedge clk);
    #1;
    RegWriteIn = 1'b0;
    chk("byp_new", ReadData1, 64'h77);

    // LDUR X1, [X2, #-8]
    load(64'h24, 32'hF85F_8041);
    chk("ldur_imm", SignExtImm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_ctrl", {54'd0, Ctrl}, {54'd0, 10'b0111100000});
    chk("ldur_pcsrc", {63'd0, PCSrc}, 64'd0);

    // STUR X1, [X2, #8]: Reg2Loc routes Rt to ReadData2
    wr(5'd1, 64'hABCD);
    load(64'h28, 32'hF800_8041);
    chk("stur_ctrl", {54'd0, Ctrl}, {54'd0, 10'b1100010000});
    chk("stur_imm", SignExtImm, 64'd8);
    chk("stur_rd2", ReadData2, 64'hABCD);

    // Write to X31 is dropped; ADD X1, X31, X31
    wr(5'd31, 64'hDEAD);
    load(64'h2C, 32'h8B1F_03E1);
    chk("x31_rd1", ReadData1, 64'd0);
    chk("x31_rd2", ReadData2, 64'd0);

    // HALT
    load(64'h30, 32'hFFE0_0000);
    chk("halt_ctrl", {54'd0, Ctrl}, 64'd0);
    chk("halt_pcsrc", {63'd0, PCSrc}, 64'd0);

    // Mid-cycle asynchronous reset while a taken B sits in decode
    wr(5'd0, 64'h55);
    load(64'h8, 32'h1400_0003);
    chk("prerst_rd1", ReadData1, 64'h55);
    chk("prerst_pcsrc", {63'd0, PCSrc}, 64'd1);
    #10;
    reset = 1'b1;
    #1;
    chk("arst_ctrl", {54'd0, Ctrl}, 64'd0);
    chk("arst_pcsrc", {63'd0, PCSrc}, 64'd0);
    chk("arst_rd1", ReadData1, 64'd0);
    chk("arst_baddr", BranchAddress, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the single-issue LEGv8 (ARMv8 subset) CPU, placed directly after instruction fetch. It latches the fetch output bundle `outBuf` (instruction and PC) each cycle and produces the main control word. It holds the 32×64 register file and returns two read operands and the sign-extended immediate. It resolves B/CBZ/CBNZ branches, driving `PCSrc` and `BranchAddress` back to fetch.

## Interface
- No parameters.
- Positional order: `outBuf, PCSrc, BranchAddress, clk, reset, RegWriteIn, WriteReg, WriteData, ReadData1, ReadData2, SignExtImm, Ctrl`. Trailing ports may be left unconnected; unconnected inputs read as 0.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `outBuf` in 96: [31:0] instruction, [95:32] PC of the next sequential instruction (branch address + 4).
- `PCSrc` out 1: 1 means fetch loads `BranchAddress`.
- `BranchAddress` out 64: branch target byte address.
- `RegWriteIn` in 1: writeback enable.
- `WriteReg` in 5: writeback register index.
- `WriteData` in 64: writeback value.
- `ReadData1` out 64: value of register Rn.
- `ReadData2` out 64: value of Rm or Rt (selected by Reg2Loc).
- `SignExtImm` out 64: sign-extended immediate.
- `Ctrl` out 10: {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch, ALUOp[1:0]}.

## Operation
- Pipeline register: IR[31:0] and PCR[63:0] capture `outBuf` on posedge `clk`. All outputs are combinational from IR, PCR and the register file.
- Opcode decode on IR[31:21]. `Ctrl` value per instruction:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: `Ctrl` = 0001000010.
  - LDUR 11111000010: `Ctrl` = 0111100000.
  - STUR 11111000000: `Ctrl` = 1100010000.
  - CBZ 10110100xxx, CBNZ 10110101xxx: `Ctrl` = 1000001001.
  - B 000101xxxxx: `Ctrl` = 0000000100.
  - HALT 11111111111 and any other opcode: `Ctrl` = 0.
- Register fields: Rn = IR[9:5]. Rm = IR[20:16]. Rt = IR[4:0]. ReadData2 reads Rt when Reg2Loc = 1, otherwise Rm.
- Register file: 32×64. X31 always reads 0, and writes to it are ignored.
  - Writes are synchronous at posedge when `RegWriteIn` = 1.
  - Reads are asynchronous, so a value written is visible on reads immediately after the edge.
- Immediate sign extension by format:
  - D-type (LDUR/STUR): IR[20:12], 9 bits.
  - CB-type: IR[23:5], 19 bits.
  - B-type: IR[25:0], 26 bits.
  - I-type/other: 0.
- Branch target: `BranchAddress` = (PCR − 4) + (`SignExtImm` << 2), 64-bit wrap-around arithmetic. Driven for every instruction; meaningful only when `PCSrc` = 1.
- `PCSrc` = UncondBranch | (CBZ & ReadData2 == 0) | (CBNZ & ReadData2 != 0).
- No flush or stall logic; fetch owns redirect handling.

## Timing
- Reset (asynchronous, takes effect mid-cycle) clears:
  - IR = 0, which decodes as an unknown opcode: `Ctrl` = 0, `PCSrc` = 0.
  - PCR = 0, so `BranchAddress` = 0xFFFF_FFFF_FFFF_FFFC. It is don't-care because `PCSrc` = 0.
  - All registers = 0.
- Decode latency is one edge. Values latched at posedge N must produce settled outputs within 40 time units (half of the 80-unit half-period), because fetch samples `PCSrc` at posedge + 40.
- `outBuf` changes on negedge, so it is stable at every posedge.
- If a writeback and a read of the same register occur in the same cycle, reads return the old value before the edge and the new value after it.

## Structure
- Shared package `legv8_pkg`: opcode constants (ADD, SUB, AND, ORR, LDUR, STUR, CBZ, CBNZ, B, HALT), `Ctrl` bit positions, ALUOp encodings.
- One sub-module `register_file` (32×64, 2 read ports, 1 write port, async reset). Control decode, sign extension and branch logic stay in the top module.

## Test plan
- Reset asserted mid-cycle → `PCSrc` = 0, `Ctrl` = 0 and all registers 0 immediately, without waiting for a clock edge.
- `outBuf` = {PC 0x8, 0x14000003} (B #3) → `PCSrc` = 1, `BranchAddress` = 0x10, `Ctrl` = 0000000100.
- X1 = 0; `outBuf` = {0x14, 0xB4000041} (CBZ X1, #2) → `PCSrc` = 1, `BranchAddress` = 0x18. Then write X1 = 5 → `PCSrc` = 0. Repeat with CBNZ (0xB5000041) → `PCSrc` = 1.
- Write X2 = 7 and X3 = 9; ADD X1, X2, X3 (0x8B030041) → `ReadData1` = 7, `ReadData2` = 9, `Ctrl` = 0001000010.
- LDUR X1, [X2, #-8] (0xF85F8041) → `SignExtImm` = 0xFFFF_FFFF_FFFF_FFF8, `Ctrl` = 0111100000. Write to X31 → X31 still reads 0.
- HALT (0xFFE00000) → `Ctrl` = 0, `PCSrc` = 0.
